// File: rtl/emu_time_pkg.sv
// Shared types and default widths for the emulated-time manager.
package emu_time_pkg;

  typedef enum logic [1:0] {
    CTRL_PAUSE     = 2'd0,
    CTRL_RUN       = 2'd1,
    CTRL_RUN_UNTIL = 2'd2,
    CTRL_RSVD      = 2'd3
  } ctrl_mode_t;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_UNTIL   = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DT_WIDTH   = 32;
  localparam int DEF_TIME_WIDTH = 48;

endpackage

// File: rtl/emu_dt_min.sv
// Combinational binary min-reduction tree over packed timestep requests.
module emu_dt_min #(
  parameter int N_REQ    = 4,
  parameter int DT_WIDTH = 32
) (
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  output logic [DT_WIDTH-1:0]       dt_min
);

  localparam int LEAVES = 1 << $clog2(N_REQ);

  // Heap layout: root at index 1, leaves at LEAVES..2*LEAVES-1.
  logic [DT_WIDTH-1:0] node [1:2*LEAVES-1];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N_REQ) begin : g_used
      assign node[LEAVES+i] = dt_req[i*DT_WIDTH +: DT_WIDTH];
    end else begin : g_pad
      assign node[LEAVES+i] = '1;
    end
  end

  for (genvar k = 1; k < LEAVES; k++) begin : g_node
    assign node[k] = (node[2*k] < node[2*k+1]) ? node[2*k] : node[2*k+1];
  end

  assign dt_min = node[1];

endmodule

// File: rtl/emu_time_mgr.sv
// Emulated-time manager: advances emu_time by the smallest requested step
// and gates model blocks through emu_ce under pause/run/run-until control.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_PAUSED  | time frozen, waiting for RUN or RUN_UNTIL
// ST_RUNNING | time advances by dt_min every cycle
// ST_UNTIL   | advancing toward target_q, last step clamped onto it
// ST_HALTED  | target reached or time saturated; left only by command
module emu_time_mgr
  import emu_time_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DT_WIDTH   = DEF_DT_WIDTH,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic                      ctrl_valid,
  input  logic [1:0]                ctrl_mode,
  input  logic [TIME_WIDTH-1:0]     ctrl_data,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic                      emu_ce,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic                      halted,
  output logic                      done_pulse,
  output logic                      time_ovf
);

  state_t                state_q, state_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic [TIME_WIDTH-1:0] target_q, target_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [DT_WIDTH-1:0]   dt_min;
  logic [TIME_WIDTH-1:0] dt_min_ext;
  logic [TIME_WIDTH-1:0] remain;
  logic [TIME_WIDTH:0]   sum;
  logic                  carry;
  logic [TIME_WIDTH-1:0] time_next;
  ctrl_mode_t            mode;

  emu_dt_min #(
    .N_REQ    (N_REQ),
    .DT_WIDTH (DT_WIDTH)
  ) u_dt_min (
    .dt_req (dt_req),
    .dt_min (dt_min)
  );

  assign mode       = ctrl_mode_t'(ctrl_mode);
  assign dt_min_ext = TIME_WIDTH'(dt_min);
  assign remain     = target_q - time_q;

  // A zero request already forces dt_min to zero, which is the model stall.
  always_comb begin
    emu_dt = '0;
    case (state_q)
      ST_RUNNING: emu_dt = ovf_q ? '0 : dt_min;
      ST_UNTIL:   emu_dt = (remain < dt_min_ext) ? remain[DT_WIDTH-1:0] : dt_min;
      default:    emu_dt = '0;
    endcase
  end

  assign sum       = {1'b0, time_q} + (TIME_WIDTH+1)'(emu_dt);
  assign carry     = sum[TIME_WIDTH];
  assign time_next = carry ? '1 : sum[TIME_WIDTH-1:0];

  // Saturation outranks any command arriving in the same cycle.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    time_d   = time_next;
    if (carry) begin
      state_d = ST_HALTED;
      ovf_d   = 1'b1;
    end else if (ctrl_valid && mode == CTRL_PAUSE) begin
      state_d = ST_PAUSED;
    end else if (ctrl_valid && mode == CTRL_RUN && state_q == ST_PAUSED) begin
      state_d = ST_RUNNING;
    end else if (ctrl_valid && mode == CTRL_RUN_UNTIL && state_q != ST_UNTIL) begin
      target_d = ctrl_data;
      // Compare against the post-edge time so the target is never overshot.
      if (ctrl_data <= time_next) begin
        state_d = ST_HALTED;
        done_d  = 1'b1;
      end else begin
        state_d = ST_UNTIL;
      end
    end else if (state_q == ST_UNTIL && time_q == target_q) begin
      state_d = ST_HALTED;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state_q  <= ST_PAUSED;
      time_q   <= '0;
      target_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      target_q <= target_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign emu_ce     = (emu_dt != '0);
  assign emu_time   = time_q;
  assign halted     = (state_q == ST_PAUSED) || (state_q == ST_HALTED);
  assign done_pulse = done_q;
  assign time_ovf   = ovf_q;

endmodule

// File: tb/tb_emu_time_mgr.sv
// Randomised self-checking bench for emu_time_mgr against a behavioural model.
module tb_emu_time_mgr;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TW   = 12;
  localparam int MAXT = (1 << TW) - 1;

  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_UNTIL = 2;
  localparam int M_HALT  = 3;

  logic          clk;
  logic          rst;
  logic [N*DW-1:0] dt_req;
  logic          ctrl_valid;
  logic [1:0]    ctrl_mode;
  logic [TW-1:0] ctrl_data;
  logic [DW-1:0] emu_dt;
  logic          emu_ce;
  logic [TW-1:0] emu_time;
  logic          halted;
  logic          done_pulse;
  logic          time_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  int r [N];
  int m_st, m_time, m_tgt, m_ovf, m_done;
  int last_dt;

  emu_time_mgr #(.N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW)) dut (
    .emu_clk    (clk),
    .emu_rst    (rst),
    .dt_req     (dt_req),
    .ctrl_valid (ctrl_valid),
    .ctrl_mode  (ctrl_mode),
    .ctrl_data  (ctrl_data),
    .emu_dt     (emu_dt),
    .emu_ce     (emu_ce),
    .emu_time   (emu_time),
    .halted     (halted),
    .done_pulse (done_pulse),
    .time_ovf   (time_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic set_req(input int a, input int b, input int c, input int d);
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    dt_req = {d[7:0], c[7:0], b[7:0], a[7:0]};
  endtask

  task automatic model_reset();
    m_st = M_PAUSE; m_time = 0; m_tgt = 0; m_ovf = 0; m_done = 0;
  endtask

  // Called at posedge+1; reset is asserted between edges to exercise the async path.
  task automatic do_reset();
    rst = 1'b1;
    ctrl_valid = 1'b0;
    #2;
    chk("rst_emu_dt", emu_dt, 0);
    chk("rst_emu_ce", emu_ce, 0);
    chk("rst_emu_time", emu_time, 0);
    chk("rst_halted", halted, 1);
    chk("rst_done", done_pulse, 0);
    chk("rst_ovf", time_ovf, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One emulated cycle: drive, compare every output to the model, advance the model.
  task automatic tick(input bit v, input int mode, input int data);
    int mn, exp_dt, sum, t_old;
    ctrl_valid = v;
    ctrl_mode  = mode[1:0];
    ctrl_data  = data[TW-1:0];
    #2;
    mn = (1 << DW) - 1;
    for (int i = 0; i < N; i++) if (r[i] < mn) mn = r[i];
    case (m_st)
      M_RUN:   exp_dt = m_ovf ? 0 : mn;
      M_UNTIL: exp_dt = ((m_tgt - m_time) < mn) ? (m_tgt - m_time) : mn;
      default: exp_dt = 0;
    endcase
    chk("emu_dt", emu_dt, exp_dt);
    chk("emu_ce", emu_ce, exp_dt != 0);
    chk("emu_time", emu_time, m_time);
    chk("halted", halted, (m_st == M_PAUSE) || (m_st == M_HALT));
    chk("done_pulse", done_pulse, m_done);
    chk("time_ovf", time_ovf, m_ovf);
    last_dt = emu_dt;

    t_old  = m_time;
    sum    = m_time + exp_dt;
    m_done = 0;
    if (sum > MAXT) begin
      m_time = MAXT; m_ovf = 1; m_st = M_HALT;
    end else begin
      m_time = sum;
      if (v && mode == 0) m_st = M_PAUSE;
      else if (v && mode == 1 && m_st == M_PAUSE) m_st = M_RUN;
      else if (v && mode == 2 && m_st != M_UNTIL) begin
        m_tgt = data & MAXT;
        if (m_tgt <= m_time) begin m_st = M_HALT; m_done = 1; end
        else m_st = M_UNTIL;
      end else if (m_st == M_UNTIL && t_old == m_tgt) begin
        m_st = M_HALT; m_done = 1;
      end
    end
    @(posedge clk); #1;
    ctrl_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int v, md, dat;
    rst = 1'b1;
    ctrl_valid = 1'b0;
    ctrl_mode = 2'd0;
    ctrl_data = '0;
    set_req(10, 20, 30, 40);
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Idle after reset: nothing moves.
    repeat (4) tick(0, 0, 0);
    chk("lit_idle_time", emu_time, 0);
    chk("lit_idle_halted", halted, 1);
    chk("lit_idle_dt", last_dt, 0);

    // RUN_UNTIL 25 with all requests 10: steps 10,10,5.
    set_req(10, 10, 10, 10);
    tick(1, 2, 25);
    tick(0, 0, 0); chk("lit_until_dt0", last_dt, 10);
    tick(0, 0, 0); chk("lit_until_dt1", last_dt, 10);
    tick(0, 0, 0); chk("lit_until_dt2", last_dt, 5);
    chk("lit_until_time", emu_time, 25);
    tick(0, 0, 0);
    chk("lit_until_done", done_pulse, 1);
    chk("lit_until_halted", halted, 1);
    tick(0, 0, 0);
    chk("lit_until_done_once", done_pulse, 0);
    chk("lit_until_dt_after", last_dt, 0);

    // Fresh start: RUN for five cycles of dt 10, pausing on the fifth.
    do_reset();
    set_req(10, 20, 30, 40);
    tick(1, 1, 0);
    repeat (4) tick(0, 0, 0);
    chk("lit_run_halted", halted, 0);
    chk("lit_run_time40", emu_time, 40);
    tick(1, 0, 0);
    chk("lit_run_time50", emu_time, 50);

    // Target already behind current time: immediate halt with done.
    tick(1, 2, 5);
    chk("lit_past_done", done_pulse, 1);
    chk("lit_past_time", emu_time, 50);
    chk("lit_past_halted", halted, 1);

    // Stall by requester 2 for three cycles while RUNNING.
    tick(1, 0, 0);
    tick(1, 1, 0);
    set_req(10, 20, 0, 40);
    repeat (3) tick(0, 0, 0);
    chk("lit_stall_time", emu_time, 50);
    chk("lit_stall_dt", last_dt, 0);
    chk("lit_stall_halted", halted, 0);
    set_req(10, 20, 30, 40);
    tick(0, 0, 0);
    chk("lit_stall_resume", emu_time, 60);

    // Approach the top of the range, then overflow.
    tick(1, 0, 0);
    chk("lit_pause_time", emu_time, 70);
    set_req(255, 255, 255, 255);
    tick(1, 2, MAXT - 5);
    repeat (20) tick(0, 0, 0);
    chk("lit_near_top", emu_time, MAXT - 5);
    chk("lit_near_halted", halted, 1);
    tick(1, 0, 0);
    set_req(10, 10, 10, 10);
    tick(1, 1, 0);
    tick(0, 0, 0);
    chk("lit_ovf_time", emu_time, MAXT);
    chk("lit_ovf_flag", time_ovf, 1);
    chk("lit_ovf_halted", halted, 1);
    tick(1, 0, 0);
    tick(1, 1, 0);
    tick(0, 0, 0);
    chk("lit_ovf_run_dt", last_dt, 0);
    chk("lit_ovf_sticky", time_ovf, 1);

    // Mid-run reset.
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 60);
        set_req(r[0], r[1], r[2], r[3]);
        v   = ($urandom_range(0, 7) == 0) ? 1 : 0;
        md  = $urandom_range(0, 3);
        dat = (m_time + $urandom_range(0, 300)) & MAXT;
        if ($urandom_range(0, 3) == 0) dat = $urandom_range(0, MAXT);
        tick(v[0], md, dat);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
